tc_array: RTL and testbench

- Parametrised successor to the single two-register-window timer/counter: N_CH independent down-counting channels behind one memory-mapped window on the CPU bridge device bus.
- New over the single timer:
  - per-channel prescaler;
  - one-shot, auto-reload and free-run modes;
  - write-1-to-clear pending status;
  - per-channel interrupt mask;
  - an aggregated interrupt vector and summary line for the bridge's HWInt inputs.

---
 rtl/tc_pkg.sv | 26 ++
 rtl/tc_channel.sv | 152 +++++++++++++++
 rtl/tc_array.sv | 54 +++++
 tb/tb_tc_array.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and constants for the timer/counter array.
// State encoding, register offsets, CTRL bit positions and mode codes.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        EXP
    } tc_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PSC_LSB  = 16;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;
    localparam logic [1:0] MODE_FREE    = 2'd2;

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers,
// prescaler and the IDLE/LOAD/CNT/EXP sequencer.
module tc_channel #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] rdata,
    output logic        irq
);
    import tc_pkg::*;

    tc_state_e        state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic             pend_q, pend_d;

    logic [31:0] wmask;
    logic [31:0] ctrl_img, ctrl_new;
    logic [31:0] preset_img, preset_new;
    logic        tick;
    logic        unused_ok;

    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    always_comb begin
        ctrl_img = '0;
        ctrl_img[CTRL_EN] = en_q;
        ctrl_img[CTRL_MODE_LSB +: 2] = mode_q;
        ctrl_img[CTRL_IM] = im_q;
        ctrl_img[CTRL_PSC_LSB +: PSC_W] = psc_q;
        preset_img = '0;
        preset_img[CNT_W-1:0] = preset_q;
    end

    assign ctrl_new   = (ctrl_img & ~wmask) | (din & wmask);
    assign preset_new = (preset_img & ~wmask) | (din & wmask);
    assign tick       = (state_q == CNT) && (psc_cnt_q == psc_q);
    assign unused_ok  = ^{ctrl_new, preset_new};

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        im_d      = im_q;
        psc_d     = psc_q;
        preset_d  = preset_q;
        count_d   = count_q;
        psc_cnt_d = psc_cnt_q;
        pend_d    = pend_q;

        // Any CTRL write also drops a pending interrupt
        if (we && reg_sel == REG_CTRL) begin
            en_d   = ctrl_new[CTRL_EN];
            mode_d = ctrl_new[CTRL_MODE_LSB +: 2];
            im_d   = ctrl_new[CTRL_IM];
            psc_d  = ctrl_new[CTRL_PSC_LSB +: PSC_W];
            pend_d = 1'b0;
        end
        if (we && reg_sel == REG_PRESET) begin
            preset_d = preset_new[CNT_W-1:0];
        end
        if (we && reg_sel == REG_STATUS && be[0] && din[0]) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (en_q) state_d = LOAD;
            end
            LOAD: begin
                count_d   = preset_q;
                psc_cnt_d = '0;
                state_d   = (preset_q == '0) ? EXP : CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    psc_cnt_d = '0;
                    count_d   = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) state_d = EXP;
                end else begin
                    psc_cnt_d = psc_cnt_q + 1'b1;
                end
            end
            EXP: begin
                // Expiry sets PEND after any clear above, so set wins
                pend_d    = 1'b1;
                psc_cnt_d = '0;
                unique case (mode_q)
                    MODE_RELOAD: state_d = LOAD;
                    MODE_FREE: begin
                        count_d = '1;
                        state_d = CNT;
                    end
                    MODE_ONESHOT, 2'b11: begin
                        en_d    = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            mode_q    <= '0;
            im_q      <= 1'b0;
            psc_q     <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            psc_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            psc_q     <= psc_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_CTRL:   rdata = ctrl_img;
            REG_PRESET: rdata = preset_img;
            REG_COUNT:  rdata[CNT_W-1:0] = count_q;
            REG_STATUS: rdata[1:0] = {state_q == CNT, pend_q};
        endcase
    end

    assign irq = pend_q & im_q;

endmodule

// File: rtl/tc_array.sv
// N_CH timer channels behind one word-addressed register window,
// with per-channel write decode, read mux and interrupt aggregation.
module tc_array #(
    parameter  int N_CH    = 2,
    parameter  int CNT_W   = 32,
    parameter  int PSC_W   = 8,
    localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CH_BITS+1:0] addr,
    input  logic               we,
    input  logic [3:0]         be,
    input  logic [31:0]        din,
    output logic [31:0]        dout,
    output logic [N_CH-1:0]    irq,
    output logic               irq_any
);
    import tc_pkg::*;

    logic [CH_BITS-1:0] ch_sel;
    logic [1:0]         reg_sel;
    logic [31:0]        rd [N_CH];

    assign ch_sel  = addr[CH_BITS+1:2];
    assign reg_sel = addr[1:0];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tc_channel #(
            .CNT_W(CNT_W),
            .PSC_W(PSC_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .we     (we && (ch_sel == CH_BITS'(g))),
            .reg_sel(reg_sel),
            .be     (be),
            .din    (din),
            .rdata  (rd[g]),
            .irq    (irq[g])
        );
    end

    // Unpopulated channel slots read as zero
    always_comb begin
        dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_BITS'(i)) dout = rd[i];
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_tc_array.sv
// Directed, table-driven bench for tc_array with three channels.
// Hand-computed register, count and interrupt timing expectations.
module tb_tc_array;
    localparam int N_CH = 3;
    localparam int AW   = 4;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic [N_CH-1:0] irq;
    logic          irq_any;

    int n_pass  = 0;
    int n_total = 0;

    vec_t tbl [18];
    int   cnt_seq [10];

    always #5 clk = ~clk;

    tc_array #(
        .N_CH (N_CH),
        .CNT_W(32),
        .PSC_W(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .be     (be),
        .din    (din),
        .dout   (dout),
        .irq    (irq),
        .irq_any(irq_any)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] b,
                      input logic [31:0] d);
        addr = a;
        be   = b;
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        be   = '0;
        din  = '0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a,
                          input logic [31:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic irq_chk(input string name, input logic [2:0] exp);
        check(name, 32'(irq), 32'(exp));
        check({name, "_any"}, 32'(irq_any), 32'(|exp));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'h8, 4'hF, 32'hFFFF_FFF6};
        tbl[1]  = '{1'b0, 4'h8, 4'h0, 32'h00FF_0006};
        tbl[2]  = '{1'b1, 4'h8, 4'h4, 32'h0012_0000};
        tbl[3]  = '{1'b0, 4'h8, 4'h0, 32'h0012_0006};
        tbl[4]  = '{1'b1, 4'h8, 4'h1, 32'h0000_0008};
        tbl[5]  = '{1'b0, 4'h8, 4'h0, 32'h0012_0008};
        tbl[6]  = '{1'b1, 4'h8, 4'h0, 32'hFFFF_FFFF};
        tbl[7]  = '{1'b0, 4'h8, 4'h0, 32'h0012_0008};
        tbl[8]  = '{1'b1, 4'h9, 4'hF, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b0, 4'h9, 4'h0, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 4'h9, 4'hA, 32'h1122_3344};
        tbl[11] = '{1'b0, 4'h9, 4'h0, 32'h11AD_33EF};
        tbl[12] = '{1'b1, 4'hA, 4'hF, 32'h0000_1234};
        tbl[13] = '{1'b0, 4'hA, 4'h0, 32'h0000_0000};
        tbl[14] = '{1'b1, 4'hC, 4'hF, 32'hFFFF_FFFF};
        tbl[15] = '{1'b0, 4'hC, 4'h0, 32'h0000_0000};
        tbl[16] = '{1'b0, 4'hD, 4'h0, 32'h0000_0000};
        tbl[17] = '{1'b0, 4'hB, 4'h0, 32'h0000_0000};
        cnt_seq = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0};

        reset = 1'b0;
        we    = 1'b0;
        addr  = '0;
        be    = '0;
        din   = '0;
        step(3);
        reset = 1'b1;
        step(1);

        for (int c = 0; c < N_CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_chk($sformatf("rst_ch%0d_r%0d", c, r), 4'(c * 4 + r), 32'h0);
            end
        end
        rd_chk("rst_ch3", 4'hC, 32'h0);
        irq_chk("rst_irq", 3'b000);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].b, tbl[i].d);
            else rd_chk($sformatf("vec%0d", i), tbl[i].a, tbl[i].d);
        end
        irq_chk("vec_irq", 3'b000);

        // Channel 0 one-shot, PRESET=5, PSC=0
        wr(4'h1, 4'hF, 32'd5);
        wr(4'h0, 4'hF, 32'h9);
        step(2);
        rd_chk("os_cnt_e2", 4'h2, 32'd5);
        rd_chk("os_run_e2", 4'h3, 32'h2);
        step(1);
        rd_chk("os_cnt_e3", 4'h2, 32'd4);
        step(4);
        rd_chk("os_cnt_e7", 4'h2, 32'd0);
        rd_chk("os_st_e7", 4'h3, 32'h0);
        irq_chk("os_irq_e7", 3'b000);
        step(1);
        irq_chk("os_irq_e8", 3'b001);
        rd_chk("os_st_e8", 4'h3, 32'h1);
        rd_chk("os_ctrl_e8", 4'h0, 32'h8);
        wr(4'h3, 4'hF, 32'h0);
        rd_chk("os_w0_keep", 4'h3, 32'h1);
        wr(4'h3, 4'hF, 32'h1);
        rd_chk("os_w1_clr", 4'h3, 32'h0);
        irq_chk("os_irq_clr", 3'b000);

        // Channel 1 auto-reload, PRESET=3, PSC=2
        wr(4'h5, 4'hF, 32'd3);
        wr(4'h4, 4'hF, 32'h0002_000B);
        step(2);
        for (int k = 0; k < 10; k++) begin
            rd_chk($sformatf("ar_cnt%0d", k), 4'h6, 32'(cnt_seq[k]));
            step(1);
        end
        irq_chk("ar_irq_e12", 3'b010);
        wr(4'h7, 4'hF, 32'h1);
        irq_chk("ar_irq_e13", 3'b000);
        step(9);
        irq_chk("ar_irq_e22", 3'b000);
        step(1);
        irq_chk("ar_irq_e23", 3'b010);
        wr(4'h7, 4'hF, 32'h1);
        step(9);
        wr(4'h7, 4'hF, 32'h1);
        rd_chk("ar_set_wins", 4'h7, 32'h1);
        irq_chk("ar_irq_e34", 3'b010);
        wr(4'h4, 4'hF, 32'h0);
        irq_chk("ar_ctrl_clr", 3'b000);
        step(2);

        // Masked one-shot on channel 0
        wr(4'h1, 4'hF, 32'd2);
        wr(4'h0, 4'hF, 32'h1);
        step(5);
        rd_chk("mask_pend", 4'h3, 32'h1);
        irq_chk("mask_irq", 3'b000);
        wr(4'h0, 4'hF, 32'h8);
        rd_chk("mask_ctrl_clr", 4'h3, 32'h0);
        irq_chk("mask_irq2", 3'b000);

        // PRESET=0 goes straight from LOAD to EXP
        wr(4'h1, 4'hF, 32'd0);
        wr(4'h0, 4'hF, 32'h9);
        step(2);
        rd_chk("p0_st_e2", 4'h3, 32'h0);
        rd_chk("p0_cnt_e2", 4'h2, 32'h0);
        step(1);
        irq_chk("p0_irq_e3", 3'b001);
        rd_chk("p0_ctrl_e3", 4'h0, 32'h8);
        wr(4'h3, 4'hF, 32'h1);

        // Free-run wraps to all-ones after expiry
        wr(4'h1, 4'hF, 32'd1);
        wr(4'h0, 4'hF, 32'h5);
        step(4);
        rd_chk("fr_cnt_e4", 4'h2, 32'hFFFF_FFFF);
        rd_chk("fr_st_e4", 4'h3, 32'h3);
        irq_chk("fr_irq_e4", 3'b000);
        step(1);
        rd_chk("fr_cnt_e5", 4'h2, 32'hFFFF_FFFE);
        wr(4'h0, 4'hF, 32'h0);
        step(2);

        // Reset in the middle of a count
        wr(4'h1, 4'hF, 32'd50);
        wr(4'h0, 4'hF, 32'h9);
        step(12);
        rd_chk("mid_cnt40", 4'h2, 32'd40);
        reset = 1'b0;
        step(1);
        rd_chk("mid_rst_cnt", 4'h2, 32'h0);
        rd_chk("mid_rst_ctrl", 4'h0, 32'h0);
        irq_chk("mid_rst_irq", 3'b000);
        reset = 1'b1;
        step(3);
        rd_chk("mid_post_st", 4'h3, 32'h0);
        rd_chk("mid_post_pre", 4'h1, 32'h0);
        irq_chk("mid_post_irq", 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
